// File: rtl/arm_seq_controller.sv
// Multi-cycle CPU control sequencer: latches the decoded opcode, evaluates the ARM condition
// field, and walks data-processing, load/store and branch instructions through Moore-decoded states.
module arm_seq_controller #(
  parameter int OPCODE_W    = 7,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [3:0]          cond,
  input  logic [31:0]         status_reg,
  input  logic                mem_ack,
  output logic                waiting,
  output logic [1:0]          wb_sel,
  output logic                sel_A,
  output logic                sel_B,
  output logic                sel_shift,
  output logic                w_en,
  output logic                en_A,
  output logic                en_B,
  output logic                en_C,
  output logic                en_S,
  output logic [ALU_OP_W-1:0] ALU_op,
  output logic                load_ir,
  output logic                load_pc,
  output logic                sel_pc,
  output logic                load_addr,
  output logic                sel_addr,
  output logic                ram_w_en,
  output logic                mem_req,
  output logic                halted,
  output logic                fault,
  output logic [CNT_W-1:0]    retired
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_ORR = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_EOR = ALU_OP_W'(7);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_LOAD_REGS, S_EXEC, S_WB, S_ADDR,
    S_MEM, S_WB_BASE, S_BRANCH, S_ADV_PC, S_HALTED, S_FAULT
  } state_t;

  state_t             state_reg, state_next;
  logic [6:0]         op_reg;
  logic [TMO_W-1:0]   tmo_reg;
  logic [CNT_W-1:0]   retired_reg;
  logic               cond_pass;
  logic               is_ldst, is_cmp, base_wb;
  logic               flag_n, flag_z, flag_c, flag_v;
  logic               unused_status;

  assign unused_status = ^status_reg[27:0];

  generate
    if (OPCODE_W > 7) begin : g_op_hi
      logic unused_op_hi;
      assign unused_op_hi = ^opcode[OPCODE_W-1:7];
    end
  endgenerate

  assign {flag_n, flag_z, flag_c, flag_v} = status_reg[31:28];

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Latched-instruction attributes; only meaningful after DECODE.
  assign is_ldst = (op_reg[6:5] == 2'b10);
  assign is_cmp  = !op_reg[6] && (op_reg[2:0] == 3'b010);
  assign base_wb = op_reg[1] || !op_reg[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_RESET;
      op_reg      <= '0;
      tmo_reg     <= '0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE)
        op_reg <= opcode[6:0];
      if (state_reg == S_MEM && !mem_ack)
        tmo_reg <= tmo_reg + TMO_W'(1);
      else
        tmo_reg <= '0;
      if (state_reg == S_BRANCH || state_reg == S_ADV_PC)
        retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign retired = retired_reg;

  always_comb begin
    state_next = state_reg;
    waiting    = 1'b1;
    wb_sel     = 2'b00;
    sel_A      = 1'b0;
    sel_B      = 1'b0;
    sel_shift  = 1'b0;
    w_en       = 1'b0;
    en_A       = 1'b0;
    en_B       = 1'b0;
    en_C       = 1'b0;
    en_S       = 1'b0;
    ALU_op     = ALU_ADD;
    load_ir    = 1'b0;
    load_pc    = 1'b0;
    sel_pc     = 1'b0;
    load_addr  = 1'b0;
    sel_addr   = 1'b0;
    ram_w_en   = 1'b0;
    mem_req    = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    case (state_reg)
      S_RESET: begin
        waiting    = 1'b0;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        load_ir    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // HLT is checked before the condition so a halt is never skipped.
        if (opcode[6:0] == 7'd1)                      state_next = S_HALTED;
        else if (opcode[6:0] == 7'd0 || !cond_pass)   state_next = S_ADV_PC;
        else if (opcode[6:5] == 2'b11)                state_next = S_BRANCH;
        else                                          state_next = S_LOAD_REGS;
      end
      S_LOAD_REGS: begin
        en_A       = op_reg[3];
        en_B       = op_reg[4];
        en_S       = op_reg[4];
        sel_shift  = op_reg[5];
        state_next = is_ldst ? S_ADDR : S_EXEC;
      end
      S_EXEC: begin
        case (op_reg[2:0])
          3'b001, 3'b010: ALU_op = ALU_SUB;
          3'b011:         ALU_op = ALU_AND;
          3'b100:         ALU_op = ALU_ORR;
          3'b101:         ALU_op = ALU_EOR;
          default:        ALU_op = ALU_ADD;
        endcase
        sel_A      = !op_reg[3];
        sel_B      = !op_reg[4];
        en_C       = 1'b1;
        en_S       = is_cmp;
        state_next = S_WB;
      end
      S_WB: begin
        w_en       = !is_cmp;
        wb_sel     = is_ldst ? 2'b01 : 2'b00;
        state_next = (is_ldst && base_wb) ? S_WB_BASE : S_ADV_PC;
      end
      S_ADDR: begin
        ALU_op     = op_reg[2] ? ALU_ADD : ALU_SUB;
        load_addr  = 1'b1;
        sel_addr   = op_reg[3];
        state_next = S_MEM;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        ram_w_en = !op_reg[4];
        // An ack in the timeout cycle still completes the access.
        if (mem_ack) begin
          if (op_reg[4])    state_next = S_WB;
          else if (base_wb) state_next = S_WB_BASE;
          else              state_next = S_ADV_PC;
        end else if (tmo_reg == TMO_W'(MEM_TIMEOUT)) begin
          state_next = S_FAULT;
        end
      end
      S_WB_BASE: begin
        w_en       = 1'b1;
        state_next = S_ADV_PC;
      end
      S_BRANCH: begin
        load_pc = 1'b1;
        sel_pc  = 1'b1;
        if (op_reg[0]) begin
          w_en   = 1'b1;
          wb_sel = 2'b10;
        end
        state_next = S_FETCH;
      end
      S_ADV_PC: begin
        load_pc    = 1'b1;
        state_next = S_FETCH;
      end
      S_HALTED: begin
        waiting = 1'b0;
        halted  = 1'b1;
      end
      S_FAULT: begin
        waiting = 1'b0;
        fault   = 1'b1;
      end
      default: begin
        waiting    = 1'b0;
        state_next = S_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_arm_seq_controller.sv
// Bench for arm_seq_controller: per-cycle output traces compared against a model that
// builds each instruction's expected cycle list directly from the instruction-class rules.
module tb_arm_seq_controller;
  localparam int TMO = 4;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    opcode = '0;
  logic [3:0]    cond = '0;
  logic [31:0]   status_reg = '0;
  logic          mem_ack = 1'b0;
  logic          waiting, sel_A, sel_B, sel_shift, w_en, en_A, en_B, en_C, en_S;
  logic [1:0]    wb_sel;
  logic [2:0]    ALU_op;
  logic          load_ir, load_pc, sel_pc, load_addr, sel_addr, ram_w_en, mem_req, halted, fault;
  logic [CW-1:0] retired;

  arm_seq_controller #(.OPCODE_W(7), .ALU_OP_W(3), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .cond(cond), .status_reg(status_reg),
    .mem_ack(mem_ack), .waiting(waiting), .wb_sel(wb_sel), .sel_A(sel_A), .sel_B(sel_B),
    .sel_shift(sel_shift), .w_en(w_en), .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_S(en_S),
    .ALU_op(ALU_op), .load_ir(load_ir), .load_pc(load_pc), .sel_pc(sel_pc),
    .load_addr(load_addr), .sel_addr(sel_addr), .ram_w_en(ram_w_en), .mem_req(mem_req),
    .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       waiting;
    logic [1:0] wb_sel;
    logic       sel_A, sel_B, sel_shift, w_en, en_A, en_B, en_C, en_S;
    logic [2:0] alu_op;
    logic       load_ir, load_pc, sel_pc, load_addr, sel_addr, ram_w_en, mem_req, halted, fault;
  } outs_t;

  outs_t exp_q[$];
  outs_t got_q[$];
  bit    exp_retire;
  int    checks = 0;
  int    failures = 0;
  int    ret_model = 0;

  function automatic outs_t obs();
    outs_t o;
    o.waiting = waiting;     o.wb_sel = wb_sel;       o.sel_A = sel_A;       o.sel_B = sel_B;
    o.sel_shift = sel_shift; o.w_en = w_en;           o.en_A = en_A;         o.en_B = en_B;
    o.en_C = en_C;           o.en_S = en_S;           o.alu_op = ALU_op;     o.load_ir = load_ir;
    o.load_pc = load_pc;     o.sel_pc = sel_pc;       o.load_addr = load_addr;
    o.sel_addr = sel_addr;   o.ram_w_en = ram_w_en;   o.mem_req = mem_req;
    o.halted = halted;       o.fault = fault;
    return o;
  endfunction

  function automatic outs_t busy();
    outs_t o = '0;
    o.waiting = 1'b1;
    return o;
  endfunction

  // Condition = predicate selected by cond[3:1], inverted by cond[0]; 1111 inverts "always".
  function automatic bit cond_ok(input logic [3:0] c, input logic [31:0] st);
    bit n, z, cf, v, base;
    n = st[31]; z = st[30]; cf = st[29]; v = st[28];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // Expected per-cycle outputs from FETCH onward; ack_wait<0 means the RAM never answers.
  function automatic void build_exp(input logic [6:0] op, input logic [3:0] c,
                                    input logic [31:0] st, input int ack_wait);
    outs_t o;
    bit    cmp;
    exp_q.delete();
    exp_retire = 1'b1;
    o = busy(); o.load_ir = 1'b1; exp_q.push_back(o);
    exp_q.push_back(busy());
    if (op == 7'd1) begin
      o = '0; o.halted = 1'b1;
      repeat (3) exp_q.push_back(o);
      exp_retire = 1'b0;
      return;
    end
    if (op != 7'd0 && cond_ok(c, st)) begin
      if (op[6:5] == 2'b11) begin
        o = busy(); o.load_pc = 1'b1; o.sel_pc = 1'b1;
        if (op[0]) begin o.w_en = 1'b1; o.wb_sel = 2'b10; end
        exp_q.push_back(o);
        return;
      end
      o = busy(); o.en_A = op[3]; o.en_B = op[4]; o.en_S = op[4]; o.sel_shift = op[5];
      exp_q.push_back(o);
      if (!op[6]) begin
        cmp = (op[2:0] == 3'b010);
        o = busy();
        case (op[2:0])
          3'd1, 3'd2: o.alu_op = 3'b001;
          3'd3:       o.alu_op = 3'b010;
          3'd4:       o.alu_op = 3'b011;
          3'd5:       o.alu_op = 3'b111;
          default:    o.alu_op = 3'b000;
        endcase
        o.sel_A = !op[3]; o.sel_B = !op[4]; o.en_C = 1'b1; o.en_S = cmp;
        exp_q.push_back(o);
        o = busy(); o.w_en = !cmp; exp_q.push_back(o);
      end else begin
        o = busy(); o.alu_op = op[2] ? 3'b000 : 3'b001; o.load_addr = 1'b1; o.sel_addr = op[3];
        exp_q.push_back(o);
        o = busy(); o.mem_req = 1'b1; o.ram_w_en = !op[4];
        if (ack_wait < 0) begin
          repeat (TMO + 1) exp_q.push_back(o);
          o = '0; o.fault = 1'b1;
          repeat (3) exp_q.push_back(o);
          exp_retire = 1'b0;
          return;
        end
        repeat (ack_wait + 1) exp_q.push_back(o);
        if (op[4]) begin o = busy(); o.w_en = 1'b1; o.wb_sel = 2'b01; exp_q.push_back(o); end
        if (op[1] || !op[3]) begin o = busy(); o.w_en = 1'b1; exp_q.push_back(o); end
      end
    end
    o = busy(); o.load_pc = 1'b1; exp_q.push_back(o);
  endfunction

  // Drives one instruction for n cycles starting at a FETCH cycle; decoder inputs are
  // scrambled after DECODE, mem_ack pulses in cycle ack_at.
  task automatic play(input logic [6:0] op, input logic [3:0] c, input logic [31:0] st,
                      input int ack_wait, input int n);
    int ack_at;
    ack_at = (ack_wait < 0) ? -1 : 4 + ack_wait;
    $display("txn op=%b cond=%h st=%h ack_wait=%0d cycles=%0d", op, c, st, ack_wait, n);
    got_q.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got_q.push_back(obs());
      if (i <= 1) begin
        opcode = op; cond = c; status_reg = st;
      end else begin
        opcode = 7'($urandom); cond = 4'($urandom); status_reg = $urandom;
      end
      mem_ack = (i == ack_at);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ret_model = 0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== outs_t'(0)) begin
        failures++; $display("FAIL reset_outs cyc%0d got=%h exp=0", i, obs());
      end
      checks++;
      if (retired !== '0) begin
        failures++; $display("FAIL reset_retired got=%0d exp=0", retired);
      end
    end
    rst = 1'b0;
    ret_model = 0;
    build_exp(7'd0, 4'hE, 32'h0, -1);
    play(7'd0, 4'hE, 32'h0, -1, exp_q.size());
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL reset_nop cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    @(posedge clk); #1;
    ret_model += int'(exp_retire);
    checks++;
    if (retired !== CW'(ret_model)) begin
      failures++; $display("FAIL reset_nop_retired got=%0d exp=%0d", retired, CW'(ret_model));
    end
  endtask

  // Data-processing and condition-code cases share one table: {opcode, cond, status}.
  task automatic test_dataproc_cond();
    logic [6:0]  ops[10]  = '{7'b0011000, 7'b0011010, 7'b0101001, 7'b0011101, 7'b0001110,
                              7'b0011000, 7'b0011000, 7'b0011000, 7'b0011000, 7'b0100011};
    logic [3:0]  cnds[10] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'h0, 4'hC, 4'hF, 4'h9, 4'h9};
    logic [31:0] sts[10]  = '{32'h0, 32'hF000_0000, 32'h1234_5678, 32'h0, 32'h0,
                              32'h0, 32'h9000_0000, 32'h4000_0000, 32'h2000_0000, 32'h4000_0000};
    for (int t = 0; t < 10; t++) begin
      build_exp(ops[t], cnds[t], sts[t], 0);
      play(ops[t], cnds[t], sts[t], 0, exp_q.size());
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL dp_cond t%0d cyc%0d got=%h exp=%h", t, i, got_q[i], exp_q[i]);
        end
      end
      @(posedge clk); #1;
      ret_model += int'(exp_retire);
      checks++;
      if (retired !== CW'(ret_model)) begin
        failures++; $display("FAIL dp_cond_retired t%0d got=%0d exp=%0d", t, retired, CW'(ret_model));
      end
    end
  endtask

  task automatic test_load_store();
    logic [6:0] ops[4]  = '{7'b1011110, 7'b1010100, 7'b1001100, 7'b1000000};
    int         waits[4] = '{3, 0, TMO, 0};
    int         nreq;
    for (int t = 0; t < 4; t++) begin
      build_exp(ops[t], 4'hE, 32'h0, waits[t]);
      play(ops[t], 4'hE, 32'h0, waits[t], exp_q.size());
      nreq = 0;
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL ldst t%0d cyc%0d got=%h exp=%h", t, i, got_q[i], exp_q[i]);
        end
        nreq += int'(got_q[i].mem_req);
      end
      checks++;
      if (nreq != waits[t] + 1) begin
        failures++; $display("FAIL ldst_mem_req_cycles t%0d got=%0d exp=%0d", t, nreq, waits[t] + 1);
      end
      @(posedge clk); #1;
      ret_model += int'(exp_retire);
      checks++;
      if (retired !== CW'(ret_model)) begin
        failures++; $display("FAIL ldst_retired t%0d got=%0d exp=%0d", t, retired, CW'(ret_model));
      end
    end
  endtask

  task automatic test_timeout();
    build_exp(7'b1001100, 4'hE, 32'h0, -1);
    play(7'b1001100, 4'hE, 32'h0, -1, exp_q.size());
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL timeout cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (retired !== CW'(ret_model) || fault !== 1'b1) begin
      failures++; $display("FAIL timeout_sticky retired=%0d fault=%b exp retired=%0d fault=1",
                           retired, fault, CW'(ret_model));
    end
    do_reset();
  endtask

  task automatic test_branch_halt();
    logic [6:0]  ops[3]  = '{7'b1100001, 7'b1100000, 7'd1};
    logic [3:0]  cnds[3] = '{4'hE, 4'h1, 4'hE};
    for (int t = 0; t < 3; t++) begin
      build_exp(ops[t], cnds[t], 32'h0, -1);
      play(ops[t], cnds[t], 32'h0, -1, exp_q.size());
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL br_hlt t%0d cyc%0d got=%h exp=%h", t, i, got_q[i], exp_q[i]);
        end
      end
      @(posedge clk); #1;
      ret_model += int'(exp_retire);
      checks++;
      if (retired !== CW'(ret_model)) begin
        failures++; $display("FAIL br_hlt_retired t%0d got=%0d exp=%0d", t, retired, CW'(ret_model));
      end
    end
    checks++;
    if (halted !== 1'b1 || waiting !== 1'b0) begin
      failures++; $display("FAIL halt_sticky halted=%b waiting=%b exp 1/0", halted, waiting);
    end
    do_reset();
  endtask

  task automatic test_abort();
    build_exp(7'b1011110, 4'hE, 32'h0, -1);
    play(7'b1011110, 4'hE, 32'h0, -1, 6);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL abort_pre cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== outs_t'(0) || retired !== '0) begin
      failures++; $display("FAIL abort_reset got=%h retired=%0d exp=0 retired=0", obs(), retired);
    end
    rst = 1'b0;
    ret_model = 0;
  endtask

  task automatic test_wrap_random(input int n);
    logic [6:0]  op;
    logic [3:0]  c;
    logic [31:0] st;
    int          aw;
    for (int t = 0; t < n; t++) begin
      op = (t < 5) ? 7'b1100000 : 7'($urandom);
      if (op == 7'd1) op = 7'd0;
      c  = (t < 5) ? 4'hE : 4'($urandom);
      st = $urandom;
      aw = int'($urandom_range(0, TMO));
      build_exp(op, c, st, aw);
      play(op, c, st, aw, exp_q.size());
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL rand t%0d cyc%0d got=%h exp=%h", t, i, got_q[i], exp_q[i]);
        end
      end
      @(posedge clk); #1;
      ret_model += int'(exp_retire);
      checks++;
      if (retired !== CW'(ret_model)) begin
        failures++; $display("FAIL rand_retired t%0d got=%0d exp=%0d", t, retired, CW'(ret_model));
      end
    end
  endtask

  initial begin
    test_reset();
    test_dataproc_cond();
    test_load_store();
    test_timeout();
    test_branch_halt();
    test_abort();
    test_wrap_random(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
